sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//
// Sequencer for a small SRAM macro modelled with real-valued analog strobes.
// Each accepted request walks through precharge, row decode, wordline access
// and (for reads) bitline sensing, then presents a response that is held
// until consumed.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/ready   : request handshake (ready only in IDLE, never in reset)
//   req_we            : 1 = write, 0 = read
//   req_addr[7:0]     : row address; values >= ROWS are rejected with resp_err
//   req_wdata         : write data (COLS bits)
//   resp_valid/ready  : response handshake (resp_valid held until consumed)
//   resp_rdata        : last successfully read word
//   resp_err          : current response refers to an out-of-range address
//   busy              : controller is not idle
//   row_sel[0:AW-1]   : binary row code to the decoder (VDD/VSS levels)
//   precharge_en, wl_en, sense_en, write_en : analog strobes (VDD/VSS)
//   bl_drive[0:COLS-1]: write bitline levels
//   bl_sense[0:COLS-1]: sensed bitline levels, thresholded at VTH
// ---------------------------------------------------------------------------
module sram_ctrl #(
  parameter int ROWS    = 16,
  parameter int COLS    = 8,
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 3,
  localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [7:0]      req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [COLS-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy,
  output real             row_sel  [0:AW-1],
  output real             precharge_en,
  output real             wl_en,
  output real             sense_en,
  output real             write_en,
  output real             bl_drive [0:COLS-1],
  input  real             bl_sense [0:COLS-1]
);

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  // Phase counter sized for the longer of the two timed phases, plus one
  // spare bit so the reload value always fits without wrapping.
  localparam int MAXC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] PRE_RELOAD = CW'(PRE_CYC - 1);
  localparam logic [CW-1:0] WL_RELOAD  = CW'(WL_CYC - 1);
  localparam logic [8:0]    ROWS_9     = 9'(ROWS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRECH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ACCESS = 3'd3,
    ST_SENSE  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // State and latched request
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [COLS-1:0] r_wdata;

  // Registered outputs (decoded from the next state so they line up
  // exactly with the state they belong to)
  logic            r_pre;
  logic            r_wl;
  logic            r_sense;
  logic            r_wr;
  logic            r_row_en;
  logic            r_resp_valid;
  logic            r_err;
  logic            r_busy;
  logic [COLS-1:0] r_rdata;

  // Next-state logic
  state_t          w_state_next;
  logic [CW-1:0]   w_cnt_next;
  logic            w_hs;
  logic            w_oob;
  logic            w_load_rdata;
  logic            w_resp_done;
  logic [COLS-1:0] w_sense_bits;

  assign w_oob = ({1'b0, req_addr} >= ROWS_9);

  // Threshold each sensed bitline against the sense-amp trip point.
  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_sense
      assign w_sense_bits[gi] = (bl_sense[gi] >= VTH);
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hs         = 1'b0;
    w_load_rdata = 1'b0;
    w_resp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_hs = 1'b1;
          if (w_oob) begin
            // Rejected requests skip the array entirely: no strobes fire.
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_PRECH;
            w_cnt_next   = PRE_RELOAD;
          end
        end
      end
      ST_PRECH: begin
        if (r_cnt == '0) begin
          w_state_next = ST_DECODE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_DECODE: begin
        w_state_next = ST_ACCESS;
        w_cnt_next   = WL_RELOAD;
      end
      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_state_next = r_we ? ST_DONE : ST_SENSE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_SENSE: begin
        // Capture happens on the edge that leaves SENSE.
        w_state_next = ST_DONE;
        w_load_rdata = 1'b1;
      end
      ST_DONE: begin
        if (resp_ready) begin
          w_state_next = ST_IDLE;
          w_resp_done  = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_pre        <= 1'b0;
      r_wl         <= 1'b0;
      r_sense      <= 1'b0;
      r_wr         <= 1'b0;
      r_row_en     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;

      if (w_hs) begin
        r_we    <= req_we;
        r_addr  <= req_addr[AW-1:0];
        r_wdata <= req_wdata;
        r_err   <= w_oob;
      end else if (w_resp_done) begin
        r_err <= 1'b0;
      end

      if (w_load_rdata) begin
        r_rdata <= w_sense_bits;
      end

      r_pre        <= (w_state_next == ST_PRECH);
      r_wl         <= (w_state_next == ST_ACCESS);
      r_wr         <= (w_state_next == ST_ACCESS) && r_we;
      r_sense      <= (w_state_next == ST_SENSE);
      r_row_en     <= (w_state_next == ST_DECODE) ||
                      (w_state_next == ST_ACCESS) ||
                      (w_state_next == ST_SENSE);
      r_resp_valid <= (w_state_next == ST_DONE);
      r_busy       <= (w_state_next != ST_IDLE);
    end
  end

  // Digital outputs. req_ready is also gated by rst so it drops the instant
  // reset rises, even though the state is already IDLE.
  assign req_ready  = (r_state == ST_IDLE) && !rst;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign busy       = r_busy;

  // Analog strobes: every level is exactly VDD or VSS.
  assign precharge_en = r_pre   ? VDD : VSS;
  assign wl_en        = r_wl    ? VDD : VSS;
  assign sense_en     = r_sense ? VDD : VSS;
  assign write_en     = r_wr    ? VDD : VSS;

  generate
    for (gi = 0; gi < AW; gi++) begin : g_row
      assign row_sel[gi] = (r_row_en && r_addr[gi]) ? VDD : VSS;
    end
    for (gi = 0; gi < COLS; gi++) begin : g_bl
      assign bl_drive[gi] = (r_wr && r_wdata[gi]) ? VDD : VSS;
    end
  endgenerate

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
//
// Directed bench for sram_ctrl (ROWS=16, COLS=8, PRE_CYC=2, WL_CYC=3).
// A cycle table drives inputs before each rising edge and checks all
// outputs half a cycle later; hand-written sequences cover reset during
// ACCESS and back-to-back reads.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

  localparam int  ROWS    = 16;
  localparam int  COLS    = 8;
  localparam int  PRE_CYC = 2;
  localparam int  WL_CYC  = 3;
  localparam int  AW      = 4;
  localparam real VDD     = 1.5;
  localparam real VSS     = 0.0;

  // Strobe codes packed as {precharge, wordline, sense, write}
  localparam logic [3:0] S0  = 4'b0000;
  localparam logic [3:0] SP  = 4'b1000;
  localparam logic [3:0] SW  = 4'b0100;
  localparam logic [3:0] SS  = 4'b0010;
  localparam logic [3:0] SWW = 4'b0101;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_we = 1'b0;
  logic [7:0]      req_addr = 8'h00;
  logic [COLS-1:0] req_wdata = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [COLS-1:0] resp_rdata;
  logic            resp_err;
  logic            busy;
  real             row_sel  [0:AW-1];
  real             precharge_en;
  real             wl_en;
  real             sense_en;
  real             write_en;
  real             bl_drive [0:COLS-1];
  real             bl_sense [0:COLS-1];

  int tests = 0;
  int fails = 0;

  sram_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .PRE_CYC(PRE_CYC), .WL_CYC(WL_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .row_sel(row_sel), .precharge_en(precharge_en), .wl_en(wl_en),
    .sense_en(sense_en), .write_en(write_en),
    .bl_drive(bl_drive), .bl_sense(bl_sense)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rready;
    logic [7:0] sense;
    logic       e_ready;
    logic       e_busy;
    logic [3:0] e_strb;
    logic [3:0] e_row;
    logic [7:0] e_bl;
    logic       e_rv;
    logic       e_err;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic we, input logic [7:0] a,
                              input logic [7:0] wd, input logic rr, input logic [7:0] sn,
                              input logic er, input logic eb, input logic [3:0] es,
                              input logic [3:0] erow, input logic [7:0] ebl,
                              input logic erv, input logic eerr, input logic [7:0] erd);
    vec_t t;
    t.valid = v;  t.we = we;   t.addr = a;     t.wdata = wd;  t.rready = rr; t.sense = sn;
    t.e_ready = er; t.e_busy = eb; t.e_strb = es; t.e_row = erow; t.e_bl = ebl;
    t.e_rv = erv; t.e_err = eerr; t.e_rdata = erd;
    return t;
  endfunction

  // 0 = exactly VSS, 1 = exactly VDD, 2 = any other level
  function automatic logic [1:0] lv(input real x);
    if (x == VDD) return 2'd1;
    if (x == VSS) return 2'd0;
    return 2'd2;
  endfunction

  task automatic set_sense(input logic [7:0] b, input real hi, input real lo);
    for (int i = 0; i < COLS; i++) bl_sense[i] = b[i] ? hi : lo;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic grab(output logic [3:0] strb, output logic [AW-1:0] row,
                      output logic [7:0] bl, output logic exact);
    logic [1:0] l;
    exact = 1'b1;
    l = lv(precharge_en); strb[3] = l[0]; if (l == 2'd2) exact = 1'b0;
    l = lv(wl_en);        strb[2] = l[0]; if (l == 2'd2) exact = 1'b0;
    l = lv(sense_en);     strb[1] = l[0]; if (l == 2'd2) exact = 1'b0;
    l = lv(write_en);     strb[0] = l[0]; if (l == 2'd2) exact = 1'b0;
    for (int i = 0; i < AW; i++) begin
      l = lv(row_sel[i]); row[i] = l[0]; if (l == 2'd2) exact = 1'b0;
    end
    for (int i = 0; i < COLS; i++) begin
      l = lv(bl_drive[i]); bl[i] = l[0]; if (l == 2'd2) exact = 1'b0;
    end
  endtask

  task automatic check_outs(input int idx, input logic e_ready, input logic e_busy,
                            input logic [3:0] e_strb, input logic [3:0] e_row,
                            input logic [7:0] e_bl, input logic e_rv, input logic e_err,
                            input logic [7:0] e_rdata);
    logic [3:0]    strb;
    logic [AW-1:0] row;
    logic [7:0]    bl;
    logic          exact;
    grab(strb, row, bl, exact);
    chk("req_ready",  idx, req_ready,  e_ready);
    chk("busy",       idx, busy,       e_busy);
    chk("strobes",    idx, strb,       e_strb);
    chk("row_sel",    idx, row,        e_row);
    chk("bl_drive",   idx, bl,         e_bl);
    chk("resp_valid", idx, resp_valid, e_rv);
    chk("resp_err",   idx, resp_err,   e_err);
    chk("resp_rdata", idx, resp_rdata, e_rdata);
    chk("levels",     idx, exact,      1'b1);
  endtask

  initial begin
    logic [3:0]    strb;
    logic [AW-1:0] row;
    logic [7:0]    bl;
    logic          exact;
    logic          seen;
    logic          got;
    int            lat;
    int            last_resp;
    int            nreq;
    int            nresp;
    logic          hs_req;
    logic          hs_resp;

    set_sense(8'h00, VDD, VSS);

    // Reset state, before any clock edge and again with clocks running.
    #2;
    check_outs(-1, 1'b0, 1'b0, S0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00);
    @(posedge clk); @(negedge clk);
    check_outs(-2, 1'b0, 1'b0, S0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 0, req_ready, 1'b1);
    @(negedge clk);

    // Read addr 5 (garbage on req_* after handshake, sense valid only at SENSE end)
    vecs.push_back(mk(1,0,8'd5, 8'h00,0,8'h00, 0,1,SP, 4'h0,8'h00,0,0,8'h00));
    vecs.push_back(mk(1,1,8'd9, 8'hFF,0,8'h00, 0,1,SP, 4'h0,8'h00,0,0,8'h00));
    vecs.push_back(mk(1,1,8'd9, 8'hFF,0,8'h00, 0,1,S0, 4'h5,8'h00,0,0,8'h00));
    vecs.push_back(mk(1,1,8'd9, 8'hFF,0,8'h00, 0,1,SW, 4'h5,8'h00,0,0,8'h00));
    vecs.push_back(mk(1,1,8'd9, 8'hFF,0,8'h00, 0,1,SW, 4'h5,8'h00,0,0,8'h00));
    vecs.push_back(mk(1,1,8'd9, 8'hFF,0,8'h00, 0,1,SW, 4'h5,8'h00,0,0,8'h00));
    vecs.push_back(mk(1,1,8'd9, 8'hFF,0,8'h00, 0,1,SS, 4'h5,8'h00,0,0,8'h00));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'hA5, 0,1,S0, 4'h0,8'h00,1,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,1,8'h00, 1,0,S0, 4'h0,8'h00,0,0,8'hA5));
    // Write 0x3C to addr 15; sensed lines must not leak into rdata
    vecs.push_back(mk(1,1,8'd15,8'h3C,0,8'hFF, 0,1,SP, 4'h0,8'h00,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'hFF, 0,1,SP, 4'h0,8'h00,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'hFF, 0,1,S0, 4'hF,8'h00,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'hFF, 0,1,SWW,4'hF,8'h3C,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'hFF, 0,1,SWW,4'hF,8'h3C,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'hFF, 0,1,SWW,4'hF,8'h3C,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'hFF, 0,1,S0, 4'h0,8'h00,1,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,1,8'hFF, 1,0,S0, 4'h0,8'h00,0,0,8'hA5));
    // Read addr 20: error in cycle 1, then DONE held 5 cycles with a pending request
    vecs.push_back(mk(1,0,8'd20,8'h00,0,8'hFF, 0,1,S0, 4'h0,8'h00,1,1,8'hA5));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1,0,8'd3,8'h00,0,8'hFF, 0,1,S0, 4'h0,8'h00,1,1,8'hA5));
    vecs.push_back(mk(1,0,8'd3, 8'h00,1,8'hFF, 1,0,S0, 4'h0,8'h00,0,0,8'hA5));
    // Pending read of addr 3 accepted one cycle after the response handshake
    vecs.push_back(mk(1,0,8'd3, 8'h00,0,8'h00, 0,1,SP, 4'h0,8'h00,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'h00, 0,1,SP, 4'h0,8'h00,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'h00, 0,1,S0, 4'h3,8'h00,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'h00, 0,1,SW, 4'h3,8'h00,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'h00, 0,1,SW, 4'h3,8'h00,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'h00, 0,1,SW, 4'h3,8'h00,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'h00, 0,1,SS, 4'h3,8'h00,0,0,8'hA5));
    vecs.push_back(mk(0,0,8'd0, 8'h00,0,8'h0F, 0,1,S0, 4'h0,8'h00,1,0,8'h0F));
    vecs.push_back(mk(0,0,8'd0, 8'h00,1,8'h00, 1,0,S0, 4'h0,8'h00,0,0,8'h0F));

    for (int k = 0; k < vecs.size(); k++) begin
      req_valid  = vecs[k].valid;
      req_we     = vecs[k].we;
      req_addr   = vecs[k].addr;
      req_wdata  = vecs[k].wdata;
      resp_ready = vecs[k].rready;
      set_sense(vecs[k].sense, VDD, VSS);
      @(posedge clk); @(negedge clk);
      check_outs(k, vecs[k].e_ready, vecs[k].e_busy, vecs[k].e_strb, vecs[k].e_row,
                 vecs[k].e_bl, vecs[k].e_rv, vecs[k].e_err, vecs[k].e_rdata);
    end
    resp_ready = 1'b0;

    // Reset during ACCESS of a write: strobes drop without a clock edge.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd7; req_wdata = 8'h81;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check_outs(100, 1'b0, 1'b1, SWW, 4'h7, 8'h81, 1'b0, 1'b0, 8'h0F);
    #2 rst = 1'b1;
    #1;
    check_outs(101, 1'b0, 1'b0, S0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); @(negedge clk);
      if (resp_valid || busy) seen = 1'b1;
    end
    chk("no_resp_after_rst", 0, seen, 1'b0);

    // First read after reset: addr 10, sensed 0x5A, response in cycle 8.
    set_sense(8'h5A, VDD, VSS);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd10;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end else begin
        @(posedge clk);
      end
    end
    chk("rst_read_latency", 0, lat, 8);
    chk("rst_read_rdata",   0, resp_rdata, 8'h5A);
    chk("rst_read_err",     0, resp_err, 1'b0);
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);

    // Back-to-back reads of addr 2 with req_valid and resp_ready held high.
    // Sense levels sit right at the threshold: 0.8 reads 1, 0.79 reads 0.
    set_sense(8'hC3, 0.8, 0.79);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd2;
    last_resp = -1;
    nreq  = 0;
    nresp = 0;
    for (int e = 0; e < 40; e++) begin
      grab(strb, row, bl, exact);
      chk("exclusion", e, {strb[3] & strb[2], strb[1] & strb[0]}, 2'b00);
      hs_req  = req_valid && req_ready;
      hs_resp = resp_valid && resp_ready;
      if (hs_resp) begin
        nresp++;
        last_resp = e;
        chk("b2b_rdata", e, resp_rdata, 8'hC3);
      end
      if (hs_req) begin
        if (last_resp >= 0) chk("b2b_gap", e, e - last_resp, 1);
        nreq++;
      end
      @(posedge clk); @(negedge clk);
    end
    chk("b2b_requests",  0, nreq, 5);
    chk("b2b_responses", 0, nresp, 4);
    req_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
